// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: FSM state encoding, oversampling
// constants and the 3-sample majority vote.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_LO  = 7;
  localparam int SAMPLE_MID = 8;
  localparam int SAMPLE_HI  = 9;
  localparam int DATA_BITS  = 8;

  // Majority of three line samples; one corrupted sample cannot flip the bit.
  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every TICK_DIV clocks.
// `clear` restarts the period so tick phase follows an external event
// (the start edge on the receive side). TICK_DIV must be >= 2.
module uart_baud_tick #(
  parameter int TICK_DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Period counter: wraps at LAST, restarts on clear.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order; reset is synchronous, so
  // rst_n is tested inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 3-sample majority vote per bit, one-entry
// valid/ready holding register with overrun and framing-error pulses.
// Default build is 8N1. Defining UART_RX_PARITY_EN makes the frame 8E1 and
// adds the parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int Clock    = 50,
  parameter int Baud     = 115200,
  parameter int TICK_DIV = Clock * 1000000 / (Baud * 16)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       frame_err,
  output logic       overrun
);

  logic       sync1, sync2, prev;
  logic       fall;
  logic       tick, clear, bit_end, maj;
  logic [3:0] tick_cnt;
  logic [2:0] samples;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic       deliver, frame_bad;
  state_t     state, state_nxt;
`ifdef UART_RX_PARITY_EN
  logic       par_bit, par_bad, parity_bad;
`endif

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign fall    = prev & ~sync2;
  assign clear   = (state == IDLE) && fall;
  assign bit_end = tick && (tick_cnt == 4'(OVERSAMPLE - 1));
  assign maj     = majority3(samples);
`ifdef UART_RX_PARITY_EN
  assign par_bad = (^shift) ^ par_bit;
`endif

  uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and end-of-frame decisions.
  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    deliver   = 1'b0;
    frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad = 1'b0;
`endif
    unique case (state)
      IDLE:  if (fall) state_nxt = START;
      START: if (bit_end) state_nxt = maj ? IDLE : DATA;
      DATA: begin
        if (bit_end && bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (bit_end) state_nxt = STOP;
`endif
      STOP: begin
        if (bit_end) begin
          state_nxt = IDLE;
          if (!maj) frame_bad = 1'b1;
`ifdef UART_RX_PARITY_EN
          else if (par_bad) parity_bad = 1'b1;
`endif
          else deliver = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit timing, majority samples and data shift register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      samples  <= '0;
      bit_idx  <= '0;
      shift    <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      if (clear)     tick_cnt <= '0;
      else if (tick) tick_cnt <= tick_cnt + 4'd1;

      if (tick) begin
        if (tick_cnt == 4'(SAMPLE_LO))  samples[0] <= sync2;
        if (tick_cnt == 4'(SAMPLE_MID)) samples[1] <= sync2;
        if (tick_cnt == 4'(SAMPLE_HI))  samples[2] <= sync2;
      end

      if (bit_end) begin
        case (state)
          START: bit_idx <= '0;
          DATA: begin
            shift   <= {maj, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
`ifdef UART_RX_PARITY_EN
          PARITY: par_bit <= maj;
`endif
          default: ;
        endcase
      end
    end
  end

  // Holding register and one-cycle error pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= frame_bad;
      overrun   <= deliver && rx_valid && !rx_ready;
`ifdef UART_RX_PARITY_EN
      parity_err <= parity_bad;
`endif
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
